iter_divider: RTL and testbench



---
 rtl/iter_divider.sv | 195 +++++++++++++++++++
 tb/tb_iter_divider.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_divider.sv
// Multi-cycle restoring integer divider: signed/unsigned, RV64 word ops, BITS_PER_CYCLE quotient bits per cycle.
// Optional macro DIV_FASTPATH_EN: divide-by-zero, overflow and |dividend| < |divisor| bypass the iteration.
module iter_divider #(
  parameter int unsigned WIDTH          = 64,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             iValidIn,
  output logic             oReadyIn,
  input  logic [WIDTH-1:0] iDivd,
  input  logic [WIDTH-1:0] iDivr,
  input  logic             iSigned,
  input  logic             iWord,
  input  logic             iFlush,
  output logic             oValid,
  input  logic             iReadyOut,
  output logic [WIDTH-1:0] oQuot,
  output logic [WIDTH-1:0] oRem,
  output logic             oDivZero
);

  localparam int unsigned CNT_W   = $clog2(WIDTH + 1);
  localparam int unsigned N_FULL  = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned N_WORD  = 32 / BITS_PER_CYCLE;
  localparam bit          WORD_OK = (WIDTH == 64);
  localparam int unsigned WSHIFT  = WORD_OK ? 32 : 0;

  if ((BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2 && BITS_PER_CYCLE != 4) ||
      (WIDTH % BITS_PER_CYCLE) != 0 || (WIDTH % 2) != 0 || WIDTH < 8) begin : g_bad_param
    $error("iter_divider: illegal WIDTH/BITS_PER_CYCLE combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q, dvd_q;
  logic             neg_quo_q, neg_rem_q, word_q, dz_q, ovf_q;
  logic             valid_q, ready_q, dz_out_q;
  logic [WIDTH-1:0] quot_out_q, rem_out_q;

  logic             word_in, a_neg, b_neg, dz_in, ovf_in;
  logic [WIDTH-1:0] a_word, b_word, min_word, a_eff, b_eff, min_eff, a_mag, b_mag;
  logic [WIDTH-1:0] rem_step, quo_step, q_fix, r_fix, q_word, r_word;
  logic [CNT_W-1:0] cnt_last;

  // Word view: low 32 bits extended per op signedness; results re-extended from bit 31.
  if (WORD_OK) begin : g_word
    assign a_word   = {{32{iSigned & iDivd[31]}}, iDivd[31:0]};
    assign b_word   = {{32{iSigned & iDivr[31]}}, iDivr[31:0]};
    assign min_word = {32'hFFFF_FFFF, 32'h8000_0000};
    assign q_word   = {{32{q_fix[31]}}, q_fix[31:0]};
    assign r_word   = {{32{r_fix[31]}}, r_fix[31:0]};
  end else begin : g_noword
    assign a_word   = iDivd;
    assign b_word   = iDivr;
    assign min_word = '0;
    assign q_word   = q_fix;
    assign r_word   = r_fix;
  end

  always_comb begin
    word_in = iWord & WORD_OK;
    a_eff   = word_in ? a_word : iDivd;
    b_eff   = word_in ? b_word : iDivr;
    min_eff = word_in ? min_word : {1'b1, {(WIDTH-1){1'b0}}};
    a_neg   = iSigned & a_eff[WIDTH-1];
    b_neg   = iSigned & b_eff[WIDTH-1];
    a_mag   = a_neg ? -a_eff : a_eff;
    b_mag   = b_neg ? -b_eff : b_eff;
    dz_in   = (b_eff == '0);
    ovf_in  = iSigned & (a_eff == min_eff) & (b_eff == '1);
  end

`ifdef DIV_FASTPATH_EN
  logic lt_in;
  assign lt_in = (a_mag < b_mag);
`endif

  // Restoring step, unrolled BITS_PER_CYCLE times; dividend bits shift out of quo_q as quotient bits shift in.
  always_comb begin
    logic [WIDTH:0] trial;
    rem_step = rem_q;
    quo_step = quo_q;
    trial    = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      trial    = {rem_step, quo_step[WIDTH-1]};
      quo_step = {quo_step[WIDTH-2:0], 1'b0};
      if (trial >= {1'b0, dvs_q}) begin
        trial       = trial - {1'b0, dvs_q};
        quo_step[0] = 1'b1;
      end
      rem_step = trial[WIDTH-1:0];
    end
  end

  always_comb begin
    cnt_last = word_q ? CNT_W'(N_WORD - 1) : CNT_W'(N_FULL - 1);
    q_fix    = neg_quo_q ? -quo_q : quo_q;
    r_fix    = neg_rem_q ? -rem_q : rem_q;
    if (dz_q) begin
      q_fix = '1;
      r_fix = dvd_q;
    end else if (ovf_q) begin
      q_fix = dvd_q;
      r_fix = '0;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      dvd_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      word_q     <= 1'b0;
      dz_q       <= 1'b0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
      ready_q    <= 1'b1;
      dz_out_q   <= 1'b0;
      quot_out_q <= '0;
      rem_out_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (iValidIn && !iFlush) begin
            state_q   <= S_CALC;
            ready_q   <= 1'b0;
            cnt_q     <= '0;
            dvd_q     <= a_eff;
            dvs_q     <= b_mag;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            word_q    <= word_in;
            dz_q      <= dz_in;
            ovf_q     <= ovf_in;
            rem_q     <= '0;
            quo_q     <= word_in ? (a_mag << WSHIFT) : a_mag;
`ifdef DIV_FASTPATH_EN
            if (dz_in || ovf_in || lt_in) begin
              state_q <= S_FIX;
              rem_q   <= a_mag;
              quo_q   <= '0;
            end
`endif
          end
        end
        S_CALC: begin
          if (iFlush) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
          end else begin
            rem_q <= rem_step;
            quo_q <= quo_step;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == cnt_last) state_q <= S_FIX;
          end
        end
        S_FIX: begin
          if (iFlush) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
          end else begin
            state_q    <= S_DONE;
            valid_q    <= 1'b1;
            quot_out_q <= word_q ? q_word : q_fix;
            rem_out_q  <= word_q ? r_word : r_fix;
            dz_out_q   <= dz_q;
          end
        end
        S_DONE: begin
          if (iFlush || iReadyOut) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign oReadyIn = ready_q;
  assign oValid   = valid_q;
  assign oQuot    = quot_out_q;
  assign oRem     = rem_out_q;
  assign oDivZero = dz_out_q;

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: directed cases plus randomized ops against an arithmetic reference model.
module tb_iter_divider;

  localparam int unsigned W   = 64;
  localparam int unsigned BPC = 2;
`ifdef DIV_FASTPATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         nRst;
  logic         iValidIn, oReadyIn, iSigned, iWord, iFlush, oValid, iReadyOut, oDivZero;
  logic [W-1:0] iDivd, iDivr, oQuot, oRem;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] last_q, last_r;
  logic         last_dz;

  iter_divider #(.WIDTH(W), .BITS_PER_CYCLE(BPC)) dut (
    .clk(clk), .nRst(nRst), .iValidIn(iValidIn), .oReadyIn(oReadyIn),
    .iDivd(iDivd), .iDivr(iDivr), .iSigned(iSigned), .iWord(iWord),
    .iFlush(iFlush), .oValid(oValid), .iReadyOut(iReadyOut),
    .oQuot(oQuot), .oRem(oRem), .oDivZero(oDivZero)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: architectural result from plain integer arithmetic on the effective-width view.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn, input bit wrd,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output bit dz, output int lat);
    logic [W-1:0] ea, eb, ma, mb;
    longint       sa, sb;
    bit           ovf;
    if (wrd) begin
      ea = sgn ? {{32{a[31]}}, a[31:0]} : {32'h0, a[31:0]};
      eb = sgn ? {{32{b[31]}}, b[31:0]} : {32'h0, b[31:0]};
      ovf = sgn && (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
    end else begin
      ea = a;
      eb = b;
      ovf = sgn && (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
    end
    dz = (eb == 64'h0);
    sa = ea;
    sb = eb;
    if (dz) begin
      q = '1;
      r = ea;
    end else if (ovf) begin
      q = ea;
      r = '0;
    end else if (sgn) begin
      q = 64'(sa / sb);
      r = 64'(sa % sb);
    end else begin
      q = ea / eb;
      r = ea % eb;
    end
    if (wrd) begin
      q = {{32{q[31]}}, q[31:0]};
      r = {{32{r[31]}}, r[31:0]};
    end
    ma = (sgn && ea[W-1]) ? -ea : ea;
    mb = (sgn && eb[W-1]) ? -eb : eb;
    if (FAST && (dz || ovf || ma < mb)) lat = 2;
    else lat = (wrd ? 32 : 64) / BPC + 2;
  endfunction

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 9))
      0:       v = {$urandom, $urandom};
      1:       v = W'($urandom_range(0, 20));
      2:       v = '1;
      3:       v = 64'h8000_0000_0000_0000;
      4:       v = {$urandom, 32'h8000_0000};
      5:       v = {$urandom, 32'h0};
      6:       v = {$urandom, 32'hFFFF_FFFF};
      7:       v = 64'h0;
      8:       v = -W'($urandom_range(1, 20));
      default: v = {32'h0, $urandom};
    endcase
    return v;
  endfunction

  task automatic accept_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn, input bit wrd);
    int guard;
    guard = 0;
    while (!oReadyIn && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("ready_in", W'(oReadyIn), W'(1));
    iDivd = a; iDivr = b; iSigned = sgn; iWord = wrd; iValidIn = 1'b1;
    @(negedge clk);
    iValidIn = 1'b0;
    iDivd    = {$urandom, $urandom};
    iDivr    = {$urandom, $urandom};
    iSigned  = 1'($urandom);
    iWord    = 1'($urandom);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!oValid && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check("valid", W'(oValid), W'(1));
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn, input bit wrd, input int hold);
    logic [W-1:0] eq, er;
    bit           edz;
    int           elat, cyc;
    ref_div(a, b, sgn, wrd, eq, er, edz, elat);
    accept_op(a, b, sgn, wrd);
    wait_valid(cyc);
    check("latency", W'(cyc), W'(elat));
    check("quot", oQuot, eq);
    check("rem", oRem, er);
    check("divzero", W'(oDivZero), W'(edz));
    check("ready_busy", W'(oReadyIn), W'(0));
    last_q = oQuot; last_r = oRem; last_dz = oDivZero;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", W'(oValid), W'(1));
      check("hold_quot", oQuot, eq);
      check("hold_rem", oRem, er);
      check("hold_ready", W'(oReadyIn), W'(0));
    end
    iReadyOut = 1'b1;
    @(negedge clk);
    iReadyOut = 1'b0;
    check("release_valid", W'(oValid), W'(0));
    check("release_ready", W'(oReadyIn), W'(1));
  endtask

  task automatic flush_at(input int k);
    logic seen;
    accept_op(64'd100, 64'd7, 1'b0, 1'b0);
    repeat (k - 1) @(negedge clk);
    iFlush = 1'b1;
    @(negedge clk);
    iFlush = 1'b0;
    check("flush_valid", W'(oValid), W'(0));
    check("flush_ready", W'(oReadyIn), W'(1));
    seen = 1'b0;
    repeat (W / BPC + 4) begin
      @(negedge clk);
      seen = seen | oValid;
    end
    check("flush_no_valid", W'(seen), W'(0));
  endtask

  initial begin
    int cyc;
    nRst = 1'b0; iValidIn = 1'b0; iDivd = '0; iDivr = '0; iSigned = 1'b0;
    iWord = 1'b0; iFlush = 1'b0; iReadyOut = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", W'(oValid), W'(0));
    check("rst_ready", W'(oReadyIn), W'(1));
    check("rst_quot", oQuot, W'(0));
    check("rst_rem", oRem, W'(0));
    check("rst_dz", W'(oDivZero), W'(0));
    nRst = 1'b1;
    @(negedge clk);

    run_op(64'd100, 64'd7, 1'b0, 1'b0, 10);
    check("tp_100_7_q", last_q, 64'd14);
    check("tp_100_7_r", last_r, 64'd2);
    run_op(-64'sd7, 64'd2, 1'b1, 1'b0, 0);
    check("tp_m7_2_q", last_q, 64'hFFFF_FFFF_FFFF_FFFD);
    check("tp_m7_2_r", last_r, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(64'd7, -64'sd2, 1'b1, 1'b0, 0);
    check("tp_7_m2_q", last_q, 64'hFFFF_FFFF_FFFF_FFFD);
    check("tp_7_m2_r", last_r, 64'd1);
    run_op(64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 0);
    check("tp_wovf_q", last_q, 64'hFFFF_FFFF_8000_0000);
    check("tp_wovf_r", last_r, 64'd0);
    run_op(64'd5, 64'd0, 1'b0, 1'b0, 1);
    check("tp_dz_q", last_q, 64'hFFFF_FFFF_FFFF_FFFF);
    check("tp_dz_r", last_r, 64'd5);
    check("tp_dz_flag", W'(last_dz), W'(1));
    run_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 0);
    run_op(64'h1234_5678_0000_0005, 64'hABCD_0000_0000_0000, 1'b1, 1'b1, 0);
    run_op(64'hFFFF_FFFF_FFFF_FFF0, 64'd3, 1'b0, 1'b1, 0);
    run_op(64'd3, 64'd10, 1'b0, 1'b0, 0);
    check("tp_3_10_q", last_q, 64'd0);
    check("tp_3_10_r", last_r, 64'd3);

    flush_at(20);
    run_op(64'd9, 64'd3, 1'b0, 1'b0, 0);
    check("tp_9_3_q", last_q, 64'd3);
    check("tp_9_3_r", last_r, 64'd0);
    flush_at(W / BPC + 1);

    // Flush while holding a result drops it even with iReadyOut low.
    accept_op(64'd50, 64'd6, 1'b0, 1'b0);
    wait_valid(cyc);
    iFlush = 1'b1;
    @(negedge clk);
    iFlush = 1'b0;
    check("done_flush_valid", W'(oValid), W'(0));
    check("done_flush_ready", W'(oReadyIn), W'(1));

    // Flush in idle blocks a simultaneous request.
    iDivd = 64'd40; iDivr = 64'd4; iValidIn = 1'b1; iFlush = 1'b1;
    @(negedge clk);
    iValidIn = 1'b0; iFlush = 1'b0;
    check("idle_flush_ready", W'(oReadyIn), W'(1));

    run_op(64'd77, 64'd7, 1'b0, 1'b0, 0);
    accept_op(64'hFFFF_0000_1111_2222, 64'd3, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    #2 nRst = 1'b0;
    #1;
    check("arst_valid", W'(oValid), W'(0));
    check("arst_ready", W'(oReadyIn), W'(1));
    check("arst_quot", oQuot, W'(0));
    check("arst_rem", oRem, W'(0));
    @(negedge clk);
    nRst = 1'b1;
    @(negedge clk);
    run_op(64'd1000, 64'd33, 1'b0, 1'b0, 0);

    for (int k = 0; k < 60; k++) begin
      logic [W-1:0] a, b;
      a = pick();
      b = pick();
      run_op(a, b, 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
